// File: rtl/alu_rs_pkg.sv
// Shared types and op codes for the ALU reservation station.
// Entry fields are sized by the package widths, which are also the top-level defaults.
package alu_rs_pkg;

    localparam int RS_OPE  = 32;
    localparam int RS_FUNC = 17;
    localparam int RS_TAG  = 5;

    localparam logic [RS_FUNC-1:0] ALU_ADD = 17'h01;
    localparam logic [RS_FUNC-1:0] ALU_SUB = 17'h02;
    localparam logic [RS_FUNC-1:0] ALU_AND = 17'h03;
    localparam logic [RS_FUNC-1:0] ALU_OR  = 17'h04;

    typedef struct packed {
        logic              rdy;
        logic [RS_TAG-1:0] tag;
        logic [RS_OPE-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic               valid;
        logic [RS_FUNC-1:0] func;
        logic [RS_TAG-1:0]  tag;
        rs_src_t            s1;
        rs_src_t            s2;
    } rs_entry_t;

endpackage

// File: rtl/rs_pick2.sv
// Finds the lowest and second-lowest set bits of a request vector.
// Returns them as one-hot grants, binary indices and valid flags.
module rs_pick2 #(
    parameter int DEPTH = 8,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] gnt0,
    output logic [DEPTH-1:0] gnt1,
    output logic [IW-1:0]    idx0,
    output logic [IW-1:0]    idx1,
    output logic             vld0,
    output logic             vld1
);

    logic [DEPTH-1:0] rest;

    // Two's-complement isolation of the lowest set bit, applied twice
    always_comb begin
        gnt0 = req & (~req + DEPTH'(1));
        rest = req & ~gnt0;
        gnt1 = rest & (~rest + DEPTH'(1));
        vld0 = |req;
        vld1 = |rest;
        idx0 = '0;
        idx1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt0[i]) idx0 = IW'(i);
            if (gnt1[i]) idx1 = IW'(i);
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Reservation station feeding the dual-lane ALU: buffers ops, snoops both CDB lanes,
// and issues up to two ready ops per cycle through registered outputs.
module alu_issue_queue
    import alu_rs_pkg::*;
#(
    parameter int OPE   = RS_OPE,
    parameter int FUNC  = RS_FUNC,
    parameter int TAG   = RS_TAG,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [FUNC-1:0]           disp_func,
    input  logic [TAG-1:0]            disp_tag,
    input  logic                      disp_s1_rdy,
    input  logic [TAG-1:0]            disp_s1_tag,
    input  logic [OPE-1:0]            disp_s1_val,
    input  logic                      disp_s2_rdy,
    input  logic [TAG-1:0]            disp_s2_tag,
    input  logic [OPE-1:0]            disp_s2_val,
    input  logic [1:0]                cdb_valid,
    input  logic [1:0][TAG-1:0]       cdb_tag,
    input  logic [1:0][OPE-1:0]       cdb_data,
    output logic [1:0]                iss_valid,
    output logic [TAG-1:0]            iss_tag1,
    output logic [TAG-1:0]            iss_tag2,
    output logic [FUNC-1:0]           op_func1,
    output logic [FUNC-1:0]           op_func2,
    output logic [OPE-1:0]            operand11,
    output logic [OPE-1:0]            operand12,
    output logic [OPE-1:0]            operand21,
    output logic [OPE-1:0]            operand22
);

    localparam int IW = $clog2(DEPTH);

    rs_entry_t        ent   [DEPTH];
    rs_entry_t        ent_n [DEPTH];
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] elig_vec;
    logic [DEPTH-1:0] iss_gnt0, iss_gnt1;
    logic [IW-1:0]    iss_idx0, iss_idx1;
    logic             iss_vld0, iss_vld1;
    logic [IW-1:0]    free_idx;
    logic             free_vld;
    logic [DEPTH-1:0] free_gnt0_unused, free_gnt1_unused;
    logic [IW-1:0]    free_idx1_unused;
    logic             free_vld1_unused;

    // Lane 0 takes precedence when both CDB lanes carry the awaited tag
    function automatic rs_src_t wake(input rs_src_t s, input logic [1:0] cv,
                                     input logic [1:0][TAG-1:0] ct,
                                     input logic [1:0][OPE-1:0] cd);
        rs_src_t r;
        r = s;
        if (!s.rdy) begin
            if (cv[0] && (s.tag == ct[0])) begin
                r.rdy = 1'b1;
                r.val = cd[0];
            end else if (cv[1] && (s.tag == ct[1])) begin
                r.rdy = 1'b1;
                r.val = cd[1];
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = !ent[i].valid;
            elig_vec[i] = ent[i].valid && ent[i].s1.rdy && ent[i].s2.rdy;
        end
    end

    rs_pick2 #(.DEPTH(DEPTH)) u_free_pick (
        .req(free_vec), .gnt0(free_gnt0_unused), .gnt1(free_gnt1_unused),
        .idx0(free_idx), .idx1(free_idx1_unused), .vld0(free_vld), .vld1(free_vld1_unused)
    );

    rs_pick2 #(.DEPTH(DEPTH)) u_iss_pick (
        .req(elig_vec), .gnt0(iss_gnt0), .gnt1(iss_gnt1),
        .idx0(iss_idx0), .idx1(iss_idx1), .vld0(iss_vld0), .vld1(iss_vld1)
    );

    assign disp_ready = free_vld;

    // The slot being written is free in the current state, so it never collides with issue
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_n[i] = ent[i];
            if (ent[i].valid) begin
                ent_n[i].s1 = wake(ent[i].s1, cdb_valid, cdb_tag, cdb_data);
                ent_n[i].s2 = wake(ent[i].s2, cdb_valid, cdb_tag, cdb_data);
            end
            if (iss_gnt0[i] || iss_gnt1[i]) ent_n[i].valid = 1'b0;
        end
        if (disp_valid && free_vld) begin
            ent_n[free_idx].valid = 1'b1;
            ent_n[free_idx].func  = disp_func;
            ent_n[free_idx].tag   = disp_tag;
            ent_n[free_idx].s1    = wake('{rdy: disp_s1_rdy, tag: disp_s1_tag, val: disp_s1_val},
                                         cdb_valid, cdb_tag, cdb_data);
            ent_n[free_idx].s2    = wake('{rdy: disp_s2_rdy, tag: disp_s2_tag, val: disp_s2_val},
                                         cdb_valid, cdb_tag, cdb_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            iss_valid <= '0;
            iss_tag1  <= '0;
            iss_tag2  <= '0;
            op_func1  <= '0;
            op_func2  <= '0;
            operand11 <= '0;
            operand12 <= '0;
            operand21 <= '0;
            operand22 <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
            iss_valid <= '0;
            iss_tag1  <= '0;
            iss_tag2  <= '0;
            op_func1  <= '0;
            op_func2  <= '0;
            operand11 <= '0;
            operand12 <= '0;
            operand21 <= '0;
            operand22 <= '0;
        end else begin
            ent       <= ent_n;
            iss_valid <= {iss_vld1, iss_vld0};
            iss_tag1  <= iss_vld0 ? ent[iss_idx0].tag    : '0;
            op_func1  <= iss_vld0 ? ent[iss_idx0].func   : '0;
            operand11 <= iss_vld0 ? ent[iss_idx0].s1.val : '0;
            operand12 <= iss_vld0 ? ent[iss_idx0].s2.val : '0;
            iss_tag2  <= iss_vld1 ? ent[iss_idx1].tag    : '0;
            op_func2  <= iss_vld1 ? ent[iss_idx1].func   : '0;
            operand21 <= iss_vld1 ? ent[iss_idx1].s1.val : '0;
            operand22 <= iss_vld1 ? ent[iss_idx1].s2.val : '0;
        end
    end

endmodule
